lightpipe_xmit: RTL and testbench

ADAT lightpipe transmitter: the send-side counterpart of `lightpipe_recv`. It captures eight 24-bit channel words and 4 user bits once per frame, serializes them into the 256-bit ADAT frame, and NRZI-encodes the result onto a single `adat` output. It runs on `mclk`, which is the bit clock (256·fs, e.g. 12.288 MHz at 48 kHz), and emits one frame bit per `mclk` cycle. It also provides a word clock and a per-frame sample strobe to upstream logic.

---
 rtl/lightpipe_xmit.sv | 89 ++++++++
 tb/tb_lightpipe_xmit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lightpipe_xmit.sv
// ADAT lightpipe transmitter: captures eight 24-bit channels plus 4 user bits once per
// 256-bit frame and NRZI-encodes the serialized frame onto adat, one bit per mclk.
module lightpipe_xmit (
    input  logic        mclk,
    input  logic        rst,
    input  logic [23:0] chan1,
    input  logic [23:0] chan2,
    input  logic [23:0] chan3,
    input  logic [23:0] chan4,
    input  logic [23:0] chan5,
    input  logic [23:0] chan6,
    input  logic [23:0] chan7,
    input  logic [23:0] chan8,
    input  logic [3:0]  user,
    output logic        adat,
    output logic        wclk,
    output logic        smp
);

    logic [7:0]  bitcnt_q, bitcnt_d;
    logic [23:0] chan_q [8];
    logic [23:0] chan_in [8];
    logic [3:0]  user_q;
    logic        adat_q, adat_d;
    logic        wclk_q;
    logic        smp_q;
    logic [255:0] frame_bits;

    assign chan_in[0] = chan1;
    assign chan_in[1] = chan2;
    assign chan_in[2] = chan3;
    assign chan_in[3] = chan4;
    assign chan_in[4] = chan5;
    assign chan_in[5] = chan6;
    assign chan_in[6] = chan7;
    assign chan_in[7] = chan8;

    // The whole frame is pure wiring from the shadow registers; bitcnt just selects a bit.
    assign frame_bits[9:0]  = '0;
    assign frame_bits[10]   = 1'b1;
    assign frame_bits[255]  = 1'b1;

    for (genvar u = 0; u < 4; u++) begin : g_user
        assign frame_bits[11 + u] = user_q[3 - u];
    end

    for (genvar k = 0; k < 48; k++) begin : g_nibble
        assign frame_bits[15 + 5*k] = 1'b1;
        for (genvar b = 0; b < 4; b++) begin : g_bit
            assign frame_bits[16 + 5*k + b] = chan_q[k/6][23 - 4*(k%6) - b];
        end
    end

    assign bitcnt_d = bitcnt_q + 8'd1;
    assign adat_d   = adat_q ^ frame_bits[bitcnt_q];

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            bitcnt_q <= '0;
            // NOTE: the shadows are reset like any other register so the first frame
            // after reset carries all-zero data rather than stale samples.
            for (int c = 0; c < 8; c++) begin
                chan_q[c] <= '0;
            end
            user_q <= '0;
            adat_q <= 1'b0;
            wclk_q <= 1'b0;
            smp_q  <= 1'b0;
        end else begin
            bitcnt_q <= bitcnt_d;
            if (bitcnt_q == 8'd255) begin
                for (int c = 0; c < 8; c++) begin
                    chan_q[c] <= chan_in[c];
                end
                user_q <= user;
            end
            adat_q <= adat_d;
            wclk_q <= (bitcnt_d < 8'd128);
            smp_q  <= (bitcnt_q == 8'd255);
        end
    end

    assign adat = adat_q;
    assign wclk = wclk_q;
    assign smp  = smp_q;

endmodule

// File: tb/tb_lightpipe_xmit.sv
// Self-checking bench for lightpipe_xmit: NRZI-decodes adat frame by frame and compares
// framing, user bits, channel nibbles and strobes against hand-written expectations.
module tb_lightpipe_xmit;

    logic        mclk = 1'b0;
    logic        rst;
    logic [23:0] chan1, chan2, chan3, chan4, chan5, chan6, chan7, chan8;
    logic [3:0]  user;
    logic        adat, wclk, smp;

    int total = 0;
    int bad   = 0;
    logic prev_adat;

    lightpipe_xmit dut (
        .mclk (mclk),
        .rst  (rst),
        .chan1(chan1),
        .chan2(chan2),
        .chan3(chan3),
        .chan4(chan4),
        .chan5(chan5),
        .chan6(chan6),
        .chan7(chan7),
        .chan8(chan8),
        .user (user),
        .adat (adat),
        .wclk (wclk),
        .smp  (smp)
    );

    always #5 mclk = ~mclk;

    typedef struct packed {
        logic [0:7][23:0] ch;
        logic [3:0]       usr;
        logic [191:0]     exp_nib;
        logic [3:0]       exp_usr;
        logic [8:0]       exp_ones;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic set_inputs(input logic [0:7][23:0] ch, input logic [3:0] usr);
        chan1 = ch[0]; chan2 = ch[1]; chan3 = ch[2]; chan4 = ch[3];
        chan5 = ch[4]; chan6 = ch[5]; chan7 = ch[6]; chan8 = ch[7];
        user  = usr;
    endtask

    // Starts at a negedge in a bitcnt==0 cycle, returns the decoded frame bits 0..255.
    // If act_at >= 0, chan3 is forced to all ones at that sample (bitcnt == act_at+1).
    task automatic run_frame(input int act_at, output logic [255:0] f);
        int smp_bad  = 0;
        int wclk_bad = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge mclk);
            f[i] = adat ^ prev_adat;
            prev_adat = adat;
            if (i == act_at) chan3 = 24'hFFFFFF;
            if (smp !== (i == 255)) smp_bad++;
            if (wclk !== (i < 127 || i == 255)) wclk_bad++;
        end
        check("smp_strobe", smp_bad, 0);
        check("wclk_strobe", wclk_bad, 0);
    endtask

    function automatic logic [191:0] get_nib(input logic [255:0] f);
        logic [191:0] r;
        for (int k = 0; k < 48; k++)
            for (int b = 0; b < 4; b++)
                r[191 - 4*k - b] = f[16 + 5*k + b];
        return r;
    endfunction

    function automatic logic [3:0] get_user(input logic [255:0] f);
        return {f[11], f[12], f[13], f[14]};
    endfunction

    function automatic logic framing_ok(input logic [255:0] f);
        logic ok = (f[9:0] == 10'd0) && f[10] && f[255];
        for (int k = 0; k < 48; k++)
            if (!f[15 + 5*k]) ok = 1'b0;
        return ok;
    endfunction

    function automatic int first_one(input logic [255:0] f);
        for (int i = 0; i < 256; i++)
            if (f[i]) return i;
        return -1;
    endfunction

    task automatic check_sync(input logic [255:0] f);
        int run = 0, long_cnt = 0, long_start = -1, max_other = 0;
        for (int i = 0; i <= 256; i++) begin
            if (i < 256 && !f[i]) begin
                run++;
            end else begin
                if (run >= 10) begin
                    long_cnt++;
                    long_start = i - run;
                end else if (run > max_other) begin
                    max_other = run;
                end
                run = 0;
            end
        end
        check("sync_count", long_cnt, 1);
        check("sync_start", long_start, 0);
        check("max_data_run_le4", (max_other <= 4), 1);
    endtask

    initial begin
        logic [255:0] f;
        logic [191:0] nib;

        vecs[0] = '{ch: {8{24'h0}}, usr: 4'h0, exp_nib: 192'h0, exp_usr: 4'h0, exp_ones: 9'd50};
        vecs[1] = '{ch: {24'hABCDEF, {7{24'h0}}}, usr: 4'h5,
                    exp_nib: {24'hABCDEF, 168'h0}, exp_usr: 4'h5, exp_ones: 9'd69};
        vecs[2] = '{ch: {{7{24'h0}}, 24'h000001}, usr: 4'h8,
                    exp_nib: {168'h0, 24'h000001}, exp_usr: 4'h8, exp_ones: 9'd52};
        vecs[3] = '{ch: {24'h0, 24'h800000, 24'h0, 24'h0, 24'h123456, 24'h0, 24'h0, 24'h0},
                    usr: 4'hF, exp_nib: {24'h0, 24'h800000, 48'h0, 24'h123456, 72'h0},
                    exp_usr: 4'hF, exp_ones: 9'd64};
        vecs[4] = '{ch: {8{24'hFFFFFF}}, usr: 4'hF,
                    exp_nib: {8{24'hFFFFFF}}, exp_usr: 4'hF, exp_ones: 9'd246};

        // Reset behaviour
        rst = 1'b1;
        set_inputs({8{24'h0}}, 4'h0);
        repeat (5) @(negedge mclk);
        check("rst_adat", adat, 0);
        check("rst_wclk", wclk, 0);
        check("rst_smp", smp, 0);
        rst = 1'b0;
        prev_adat = 1'b0;

        run_frame(-1, f);
        check("f1_toggles", $countones(f), 50);
        check("f1_sync_zero", f[9:0], 0);
        check("f1_first_toggle", first_one(f), 10);
        check("f1_end_level", adat, 0);
        check("f1_data_zero", get_nib(f), 0);

        // Table-driven data mapping: load during one frame, decode the next.
        for (int v = 0; v < 5; v++) begin
            set_inputs(vecs[v].ch, vecs[v].usr);
            run_frame(-1, f);
            run_frame(-1, f);
            check($sformatf("v%0d_framing", v), framing_ok(f), 1);
            check($sformatf("v%0d_user", v), get_user(f), vecs[v].exp_usr);
            check($sformatf("v%0d_nibbles", v), get_nib(f), vecs[v].exp_nib);
            check($sformatf("v%0d_ones", v), $countones(f), vecs[v].exp_ones);
        end

        // Capture isolation: chan3 changes mid-frame at bitcnt==100.
        set_inputs({8{24'h0}}, 4'h0);
        run_frame(-1, f);
        run_frame(99, f);
        nib = get_nib(f);
        check("iso_cur_chan3", nib[143:120], 24'h0);
        run_frame(-1, f);
        check("iso_next_nibbles", get_nib(f), {48'h0, 24'hFFFFFF, 120'h0});

        // Sync uniqueness over random frames.
        for (int fr = 0; fr < 20; fr++) begin
            chan1 = 24'($urandom()); chan2 = 24'($urandom());
            chan3 = 24'($urandom()); chan4 = 24'($urandom());
            chan5 = 24'($urandom()); chan6 = 24'($urandom());
            chan7 = 24'($urandom()); chan8 = 24'($urandom());
            user  = 4'($urandom());
            run_frame(-1, f);
            check_sync(f);
        end

        // Mid-frame reset with nonzero data in flight.
        set_inputs({24'h123456, 24'h789ABC, 24'hDEF012, 24'h345678,
                    24'h9ABCDE, 24'hF01234, 24'h56789A, 24'hBCDEF0}, 4'hA);
        run_frame(-1, f);
        repeat (100) @(negedge mclk);
        check("mid_wclk_before", wclk, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_adat", adat, 0);
        check("mid_rst_wclk", wclk, 0);
        check("mid_rst_smp", smp, 0);
        repeat (3) @(negedge mclk);
        rst = 1'b0;
        prev_adat = 1'b0;
        run_frame(-1, f);
        check("post_rst_framing", framing_ok(f), 1);
        check("post_rst_first_toggle", first_one(f), 10);
        check("post_rst_user", get_user(f), 0);
        check("post_rst_nibbles", get_nib(f), 0);
        check("post_rst_toggles", $countones(f), 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
